// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - LC-3 MAR/MDR memory access stage with req/ready handshake
// Define MEM_ACCESS_MMIO_EN to decode KBSR/KBDR/DSR/DDR locally instead of going to memory.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] busIn,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic              GateMDR,
  output logic [DATA_W-1:0] MDRToBus,
  output logic              R,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memReq,
  output logic              memWe,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memReady,
  input  logic [7:0]        kbdData,
  input  logic              kbdValid,
  output logic              kbdAck,
  output logic [7:0]        dispData,
  output logic              dispValid,
  input  logic              dispReady
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] rdbuf_q, rdbuf_d;
  logic              mmio_hit;
  logic [DATA_W-1:0] mmio_rdata;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rdbuf_d = rdbuf_q;

    // MAR is frozen while a transaction is outstanding so memAddr stays stable.
    if (LD_MAR && (state_q == IDLE || state_q == HOLD)) begin
      mar_d = ADDR_W'(busIn);
    end

    if (LD_MDR) begin
      if (!MIO_EN) begin
        mdr_d = busIn;
      end else if (!R_W && state_q == DONE) begin
        mdr_d = rdbuf_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          if (mmio_hit) begin
            state_d = DONE;
            if (!R_W) rdbuf_d = mmio_rdata;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (memReady) begin
          state_d = DONE;
          if (!R_W) rdbuf_d = memRData;
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    if (!MIO_EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdbuf_q <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdbuf_q <= rdbuf_d;
    end
  end

  assign memReq   = (state_q == REQ);
  assign memWe    = memReq & R_W;
  assign memAddr  = mar_q;
  assign memWData = mdr_q;
  assign R        = (state_q == DONE);
  assign MDRToBus = GateMDR ? mdr_q : {DATA_W{1'bz}};

`ifdef MEM_ACCESS_MMIO_EN
  localparam logic [ADDR_W-1:0] KBSR_A = ADDR_W'(16'hFE00);
  localparam logic [ADDR_W-1:0] KBDR_A = ADDR_W'(16'hFE02);
  localparam logic [ADDR_W-1:0] DSR_A  = ADDR_W'(16'hFE04);
  localparam logic [ADDR_W-1:0] DDR_A  = ADDR_W'(16'hFE06);

  logic       mmio_q, mmio_d;
  logic       mmio_we_q, mmio_we_d;
  logic [1:0] mmio_reg_q, mmio_reg_d;
  logic [7:0] disp_data_q, disp_data_d;

  always_comb begin
    mmio_hit = (mar_q == KBSR_A) || (mar_q == KBDR_A) ||
               (mar_q == DSR_A)  || (mar_q == DDR_A);
    case (mar_q)
      KBSR_A:  mmio_rdata = {kbdValid, {(DATA_W-1){1'b0}}};
      KBDR_A:  mmio_rdata = {{(DATA_W-8){1'b0}}, kbdData};
      DSR_A:   mmio_rdata = {dispReady, {(DATA_W-1){1'b0}}};
      default: mmio_rdata = '0;
    endcase

    mmio_d      = mmio_q;
    mmio_we_d   = mmio_we_q;
    mmio_reg_d  = mmio_reg_q;
    disp_data_d = disp_data_q;
    // Snapshot the decode while idle; the value at the launching edge is what DONE sees.
    if (state_q == IDLE) begin
      mmio_d     = mmio_hit;
      mmio_we_d  = R_W;
      mmio_reg_d = mar_q[2:1];
    end
    if (state_q == IDLE && MIO_EN && R_W && mar_q == DDR_A) begin
      disp_data_d = mdr_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_q      <= 1'b0;
      mmio_we_q   <= 1'b0;
      mmio_reg_q  <= 2'd0;
      disp_data_q <= 8'd0;
    end else begin
      mmio_q      <= mmio_d;
      mmio_we_q   <= mmio_we_d;
      mmio_reg_q  <= mmio_reg_d;
      disp_data_q <= disp_data_d;
    end
  end

  assign kbdAck    = (state_q == DONE) && mmio_q && !mmio_we_q && (mmio_reg_q == 2'd1);
  assign dispValid = (state_q == DONE) && mmio_q &&  mmio_we_q && (mmio_reg_q == 2'd3);
  assign dispData  = disp_data_q;
`else
  logic unused_mmio;

  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = '0;
  assign kbdAck      = 1'b0;
  assign dispValid   = 1'b0;
  assign dispData    = 8'd0;
  assign unused_mmio = ^{kbdData, kbdValid, dispReady};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized checks of mem_access_unit
// Memory is modelled as an address->data map; expected values come from that map.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] busIn;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W, GateMDR;
  wire  [15:0] MDRToBus;
  logic        R;
  logic [15:0] memAddr, memWData;
  logic        memReq, memWe;
  logic [15:0] memRData;
  logic        memReady;
  logic [7:0]  kbdData;
  logic        kbdValid;
  logic        kbdAck;
  logic [7:0]  dispData;
  logic        dispValid;
  logic        dispReady;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] ref_mem [logic [15:0]];

  mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .busIn(busIn), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .GateMDR(GateMDR), .MDRToBus(MDRToBus), .R(R),
    .memAddr(memAddr), .memWData(memWData), .memReq(memReq), .memWe(memWe),
    .memRData(memRData), .memReady(memReady), .kbdData(kbdData), .kbdValid(kbdValid),
    .kbdAck(kbdAck), .dispData(dispData), .dispValid(dispValid), .dispReady(dispReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete CPU-style access: load MAR (and MDR for writes), handshake, then read MDR back.
  task automatic access(input logic [15:0] addr, input bit wr, input logic [15:0] wdata,
                        input int lat, input int hold);
    logic [15:0] exp_rd;
    exp_rd = 16'h0000;
    busIn = addr; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
    if (wr) begin
      busIn = wdata; LD_MDR = 1'b1; MIO_EN = 1'b0; tick(); LD_MDR = 1'b0;
    end else begin
      if (!ref_mem.exists(addr)) ref_mem[addr] = 16'($urandom);
      exp_rd = ref_mem[addr];
    end
    MIO_EN = 1'b1; R_W = wr; tick();
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk("memReq_active", {15'd0, memReq}, 16'd1);
      chk("memWe", {15'd0, memWe}, {15'd0, wr});
      chk("memAddr", memAddr, addr);
      if (wr) chk("memWData", memWData, wdata);
      chk("R_during_req", {15'd0, R}, 16'd0);
      memReady = (c == lat);
      memRData = (c == lat) ? exp_rd : 16'($urandom);
    end
    tick();
    memReady = 1'b0;
    @(negedge clk);
    chk("R_pulse", {15'd0, R}, 16'd1);
    chk("memReq_done", {15'd0, memReq}, 16'd0);
    if (!wr) LD_MDR = 1'b1;
    tick(); LD_MDR = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("R_hold", {15'd0, R}, 16'd0);
      chk("memReq_hold", {15'd0, memReq}, 16'd0);
      tick();
    end
    MIO_EN = 1'b0; tick();
    if (wr) ref_mem[addr] = wdata;
    GateMDR = 1'b1;
    @(negedge clk);
    chk("mdr_after", MDRToBus, wr ? wdata : exp_rd);
    GateMDR = 1'b0;
  endtask

  initial begin
    logic [15:0] a, d;
    bit          w;
    rst_n = 1'b0; busIn = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0; GateMDR = 1'b1;
    memRData = '0; memReady = 0; kbdData = '0; kbdValid = 0; dispReady = 0;

    #12;
    chk("rst_mdr_bus", MDRToBus, 16'h0000);
    chk("rst_R", {15'd0, R}, 16'd0);
    chk("rst_memReq", {15'd0, memReq}, 16'd0);
    chk("rst_memWe", {15'd0, memWe}, 16'd0);
    chk("rst_memAddr", memAddr, 16'h0000);
    chk("rst_kbdAck", {15'd0, kbdAck}, 16'd0);
    chk("rst_dispValid", {15'd0, dispValid}, 16'd0);
    chk("rst_dispData", {8'd0, dispData}, 16'd0);
    rst_n = 1'b1;
    GateMDR = 1'b0;
    #1;
    vectors++;
    assert (MDRToBus === 16'hzzzz) else begin
      miscompares++;
      $error("FAIL mdr_bus_z: observed %h expected zzzz", MDRToBus);
    end
    tick();

    // Write at minimum latency; memReady already high while idle must be ignored.
    memReady = 1'b1;
    access(16'h3000, 1'b1, 16'hBEEF, 0, 0);
    memReady = 1'b0;

    // Read with five request cycles, MIO_EN held three more cycles after R.
    ref_mem[16'h4000] = 16'h1234;
    access(16'h4000, 1'b0, 16'h0000, 4, 3);

    // Drop MIO_EN and try to reload MAR mid-request: access must still finish.
    busIn = 16'h6000; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
    MIO_EN = 1'b1; R_W = 1'b0; tick();
    @(negedge clk);
    MIO_EN = 1'b0; LD_MAR = 1'b1; busIn = 16'h5555;
    tick(); LD_MAR = 1'b0;
    @(negedge clk);
    chk("req_no_abort", {15'd0, memReq}, 16'd1);
    chk("mar_frozen_req", memAddr, 16'h6000);
    memReady = 1'b1; memRData = 16'hAAAA;
    tick(); memReady = 1'b0;
    @(negedge clk);
    chk("R_after_drop", {15'd0, R}, 16'd1);
    tick(); tick();
    @(negedge clk);
    chk("mar_kept", memAddr, 16'h6000);
    chk("idle_no_req", {15'd0, memReq}, 16'd0);

    // Asynchronous reset in the middle of a request.
    busIn = 16'h7000; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
    busIn = 16'h1111; LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
    MIO_EN = 1'b1; R_W = 1'b1; tick();
    @(negedge clk);
    chk("pre_rst_req", {15'd0, memReq}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {15'd0, memReq}, 16'd0);
    chk("async_rst_mar", memAddr, 16'h0000);
    chk("async_rst_mdr", memWData, 16'h0000);
    MIO_EN = 1'b0; R_W = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    access(16'h7000, 1'b1, 16'h2222, 1, 1);
    access(16'h7000, 1'b0, 16'h0000, 2, 0);

`ifdef MEM_ACCESS_MMIO_EN
    kbdValid = 1'b1; kbdData = 8'h41;
    busIn = 16'hFE02; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
    MIO_EN = 1'b1; R_W = 1'b0; tick();
    @(negedge clk);
    chk("kbdr_no_req", {15'd0, memReq}, 16'd0);
    chk("kbdr_R", {15'd0, R}, 16'd1);
    chk("kbdr_ack", {15'd0, kbdAck}, 16'd1);
    LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
    @(negedge clk);
    chk("kbdr_ack_end", {15'd0, kbdAck}, 16'd0);
    MIO_EN = 1'b0; tick();
    GateMDR = 1'b1; @(negedge clk);
    chk("kbdr_mdr", MDRToBus, 16'h0041);
    GateMDR = 1'b0;
    busIn = 16'hFE06; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
    busIn = 16'h0058; LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
    MIO_EN = 1'b1; R_W = 1'b1; tick();
    @(negedge clk);
    chk("ddr_no_req", {15'd0, memReq}, 16'd0);
    chk("ddr_R", {15'd0, R}, 16'd1);
    chk("ddr_valid", {15'd0, dispValid}, 16'd1);
    chk("ddr_data", {8'd0, dispData}, 16'h0058);
    tick();
    @(negedge clk);
    chk("ddr_valid_end", {15'd0, dispValid}, 16'd0);
    MIO_EN = 1'b0; tick();
`else
    kbdValid = 1'b1; kbdData = 8'h41;
    access(16'hFE02, 1'b0, 16'h0000, 1, 0);
    chk("nommio_kbdAck", {15'd0, kbdAck}, 16'd0);
    access(16'hFE06, 1'b1, 16'h0058, 0, 0);
    chk("nommio_dispData", {8'd0, dispData}, 16'd0);
    chk("nommio_dispValid", {15'd0, dispValid}, 16'd0);
`endif

    // Randomized accesses over a small address pool so reads revisit earlier writes.
    for (int t = 0; t < 24; t++) begin
      a = 16'h1000 | 16'(($urandom_range(0, 7)) << 4);
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      access(a, w, d, $urandom_range(0, 4), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MAR/MDR memory interface stage directly downstream of the MAR mux on the LC-3 datapath bus.
- Latches the address from the bus into MAR and data into MDR.
- Runs a req/ready handshake with external memory and returns the ready flag R to the control FSM.
- Drives MDR back onto the shared bus through a gated tri-state output.

Parameters:
ADDR_W, 16, address width of MAR and memAddr
DATA_W, 16, data width of MDR and bus

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
busIn  in  16  shared datapath bus
LD_MAR  in  1  load MAR from busIn
LD_MDR  in  1  load MDR (source chosen by MIO_EN/R_W)
MIO_EN  in  1  memory access request from control FSM
R_W  in  1  1 = write, 0 = read
GateMDR  in  1  drive MDR onto bus
MDRToBus  out  16  MDR when GateMDR=1, else high-Z
R  out  1  access-complete pulse to control FSM
memAddr  out  16  memory address (= MAR)
memWData  out  16  memory write data (= MDR)
memReq  out  1  memory request
memWe  out  1  memory write enable
memRData  in  16  memory read data
memReady  in  1  memory completion
kbdData  in  8  keyboard character
kbdValid  in  1  keyboard character available
kbdAck  out  1  keyboard character consumed pulse
dispData  out  8  display character
dispValid  out  1  display write pulse
dispReady  in  1  display can accept a character

Behaviour:
- Reset (async, rst_n=0): MAR=0, MDR=0, rdBuf=0, state=IDLE. memReq=0, memWe=0, R=0, kbdAck=0, dispValid=0, dispData=0.
- Reset mid-access abandons the transaction immediately; memReq drops asynchronously.
- MAR: loads busIn on clk when LD_MAR=1 and state is IDLE or HOLD. LD_MAR is ignored in REQ/DONE.
- MDR source on LD_MDR:
  - MIO_EN=1 and R_W=0 in state DONE: loads rdBuf.
  - MIO_EN=0: loads busIn.
  - Any other combination: MDR holds.
- memAddr=MAR and memWData=MDR continuously. memWe=R_W while memReq=1, else 0.
- FSM states: IDLE, REQ, DONE, HOLD.
  - IDLE: MIO_EN=1 -> REQ (MMIO address with MMIO_EN -> DONE directly).
  - REQ: memReq=1. memReady=1 -> DONE; on a read, rdBuf<=memRData on the same edge. Otherwise stay in REQ. Deasserting MIO_EN in REQ does not abort; the access finishes.
  - DONE: R=1 for exactly one cycle -> HOLD.
  - HOLD: stays while MIO_EN=1 (prevents a re-issue); MIO_EN=0 -> IDLE.
- Minimum latency: MIO_EN sampled at edge 0, memReq high in cycle 1, memReady in cycle 1 -> R high in cycle 2.
- memReady outside REQ is ignored.
- MDRToBus = GateMDR ? MDR : 16'hZZZZ, combinational.

Optional Feature:
Macro: MEM_ACCESS_MMIO_EN
- Defined: addresses xFE00 (KBSR), xFE02 (KBDR), xFE04 (DSR), xFE06 (DDR) are decoded locally. memReq stays 0; IDLE -> DONE, so R rises 1 cycle after MIO_EN is sampled.
- Reads:
  - KBSR -> {kbdValid,15'b0}
  - KBDR -> {8'b0,kbdData}, with kbdAck=1 during DONE
  - DSR -> {dispReady,15'b0}
  - DDR -> 0
- Writes:
  - DDR: dispData<=MDR[7:0], with dispValid=1 during DONE.
  - KBSR/KBDR/DSR: write is ignored; R still pulses.
- Undefined: these addresses go to memory like any other. kbdAck, dispValid and dispData are tied to 0; kbdData, kbdValid and dispReady are unused.

Test Plan:
- Reset then GateMDR=1 -> MDRToBus=0x0000; GateMDR=0 -> MDRToBus=Z; R=0, memReq=0.
- busIn=0x3000 with LD_MAR; busIn=0xBEEF with LD_MDR, MIO_EN=0; then MIO_EN=1, R_W=1, memReady=1 immediately -> memReq=1, memWe=1, memAddr=0x3000, memWData=0xBEEF in cycle 1; R=1 in cycle 2 only.
- MAR=0x4000, read, memReady delayed 5 cycles with memRData=0x1234; LD_MDR in DONE -> memReq held 5 cycles, R pulses once, MDR=0x1234. MIO_EN held high 3 more cycles -> no second memReq.
- Drop MIO_EN and pulse LD_MAR with busIn=0x5555 while in REQ -> access completes at memReady, R pulses, MAR still the old value.
- Assert rst_n=0 mid-REQ -> memReq=0 immediately, MAR=MDR=0, state IDLE; a new access after reset works normally.
- With MEM_ACCESS_MMIO_EN: kbdValid=1, kbdData=0x41, read xFE02 -> no memReq, R in cycle 1, MDR=0x0041, kbdAck pulse. Write 0x0058 to xFE06 -> dispData=0x58, dispValid pulse. Without the macro, the same read issues memReq.
